// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller:
// FSM encoding, line geometry and the word-select helper.
package icache_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FILL  = 2'd2
   } state_t;

   localparam int LINE_BITS = 256;
   localparam int WORD_BITS = 32;
   localparam int OFFSET_W  = 5;
   localparam int WSEL_LSB  = 2;
   localparam int WSEL_W    = 3;

   // Word w of a line occupies bits [32w+31:32w]
   function automatic logic [WORD_BITS-1:0] word_sel(
      input logic [LINE_BITS-1:0] line,
      input logic [WSEL_W-1:0]    sel
   );
      return line[{sel, 5'd0} +: WORD_BITS];
   endfunction

endpackage

// File: rtl/icache_sram.sv
// Tag/valid/data storage: one write port, one asynchronous read port and a
// global valid-clear that a same-edge write can override for its own line.
module icache_sram
   import icache_ctrl_pkg::*;
#(
   parameter int LINE_NUM = 16,
   parameter int IDX_W    = 4,
   parameter int TAG_W    = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic                 rd_valid,
   output logic [TAG_W-1:0]     rd_tag,
   output logic [LINE_BITS-1:0] rd_data,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [TAG_W-1:0]     wr_tag,
   input  logic [LINE_BITS-1:0] wr_data,
   input  logic                 clr_all
);

   logic [LINE_NUM-1:0]  valid_r;
   logic [TAG_W-1:0]     tag_r  [LINE_NUM];
   logic [LINE_BITS-1:0] data_r [LINE_NUM];

   // Valid bits: the global clear lands first, the written line is then re-validated
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {LINE_NUM{1'b0}};
      end else begin
         if (clr_all) begin
            valid_r <= {LINE_NUM{1'b0}};
         end
         if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; the valid bits qualify them
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_r[wr_idx]  <= wr_tag;
         data_r[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_r[rd_idx];
   assign rd_tag   = tag_r[rd_idx];
   assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: combinational hit path, and a
// three-state refill FSM that fetches one 256-bit line per miss.
module icache_ctrl
   import icache_ctrl_pkg::*;
#(
   parameter int LINE_NUM = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   input  logic [31:0]          addr_i,
   input  logic                 inval_i,
   output logic [31:0]          inst_o,
   output logic                 stall_o,
   output logic                 mem_enable_o,
   output logic [31:0]          mem_addr_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);

   localparam int IDX_W = $clog2(LINE_NUM);
   localparam int TAG_W = 32 - OFFSET_W - IDX_W;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [TAG_W-1:0]     fill_tag_r;
   logic [IDX_W-1:0]     fill_idx_r;
   logic [LINE_BITS-1:0] line_buf_r;
   logic                 inval_pend_r;
   logic                 mem_enable_r;
   logic [31:0]          mem_addr_r;

   logic [IDX_W-1:0]     idx_s;
   logic [TAG_W-1:0]     tag_s;
   logic [WSEL_W-1:0]    wsel_s;
   logic                 rd_valid_s;
   logic [TAG_W-1:0]     rd_tag_s;
   logic [LINE_BITS-1:0] rd_data_s;
   logic                 hit_s;
   logic                 stall_s;
   logic [31:0]          inst_s;
   logic                 miss_start_s;
   logic                 ack_take_s;
   logic                 fill_s;
   logic                 pend_set_s;
   logic                 clr_all_s;
   logic                 unused_s;

   assign idx_s    = addr_i[OFFSET_W +: IDX_W];
   assign tag_s    = addr_i[OFFSET_W + IDX_W +: TAG_W];
   assign wsel_s   = addr_i[WSEL_LSB +: WSEL_W];
   assign unused_s = ^addr_i[1:0];

   icache_sram #(
      .LINE_NUM (LINE_NUM),
      .IDX_W    (IDX_W),
      .TAG_W    (TAG_W)
   ) u_sram (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .rd_idx   (idx_s),
      .rd_valid (rd_valid_s),
      .rd_tag   (rd_tag_s),
      .rd_data  (rd_data_s),
      .wr_en    (fill_s),
      .wr_idx   (fill_idx_r),
      .wr_tag   (fill_tag_r),
      .wr_data  (line_buf_r),
      .clr_all  (clr_all_s)
   );

   assign hit_s = rd_valid_s && (rd_tag_s == tag_s);

   // Next-state, stall, hit data and datapath strobes
   always_comb begin
      state_nxt_s  = state_r;
      stall_s      = 1'b0;
      inst_s       = 32'd0;
      miss_start_s = 1'b0;
      ack_take_s   = 1'b0;
      fill_s       = 1'b0;
      pend_set_s   = 1'b0;
      clr_all_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            stall_s   = req_i & ~hit_s;
            clr_all_s = inval_i;
            if (hit_s) begin
               inst_s = word_sel(rd_data_s, wsel_s);
            end else begin
               inst_s = 32'd0;
            end
            if (req_i && !hit_s) begin
               state_nxt_s  = ST_FETCH;
               miss_start_s = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            stall_s    = 1'b1;
            pend_set_s = inval_i;
            if (mem_ack_i) begin
               state_nxt_s = ST_FILL;
               ack_take_s  = 1'b1;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_FILL: begin
            // An invalidate arriving in this very cycle is folded into the pending one
            stall_s     = 1'b1;
            fill_s      = 1'b1;
            clr_all_s   = inval_pend_r | inval_i;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, refill tag/index, memory request and pending invalidate
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r      <= ST_IDLE;
         fill_tag_r   <= {TAG_W{1'b0}};
         fill_idx_r   <= {IDX_W{1'b0}};
         mem_enable_r <= 1'b0;
         mem_addr_r   <= 32'd0;
         inval_pend_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (miss_start_s) begin
            fill_tag_r   <= tag_s;
            fill_idx_r   <= idx_s;
            mem_addr_r   <= {tag_s, idx_s, {OFFSET_W{1'b0}}};
            mem_enable_r <= 1'b1;
         end else if (ack_take_s) begin
            mem_enable_r <= 1'b0;
         end
         if (fill_s) begin
            inval_pend_r <= 1'b0;
         end else if (pend_set_s) begin
            inval_pend_r <= 1'b1;
         end
      end
   end

   // Line buffer captures the refill on the ack edge
   always_ff @(posedge clk_i) begin
      if (ack_take_s) begin
         line_buf_r <= mem_data_i;
      end
   end

   assign stall_o      = stall_s & rst_i;
   assign inst_o       = inst_s;
   assign mem_enable_o = mem_enable_r;
   assign mem_addr_o   = mem_addr_r;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: table of fetches with a scoreboard of
// expected instruction words, plus hand-written invalidate/redirect/reset cases.
module tb_icache_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         req_i = 1'b0;
   logic [31:0]  addr_i = 32'd0;
   logic         inval_i = 1'b0;
   logic [31:0]  inst_o;
   logic         stall_o;
   logic         mem_enable_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_i = 256'd0;
   logic         mem_ack_i = 1'b0;

   icache_ctrl #(.LINE_NUM(16)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .addr_i       (addr_i),
      .inval_i      (inval_i),
      .inst_o       (inst_o),
      .stall_o      (stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;
   int stall_cnt = 0;
   logic [31:0] exp_q[$];

   always @(negedge clk_i) begin
      if (stall_o) stall_cnt <= stall_cnt + 1;
   end

   typedef struct {
      logic [31:0] addr;
      bit          miss;
      int          lat;
   } vec_t;
   vec_t vecs[11];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0044) return 32'h0010_0093;
      return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] line_of(input logic [31:0] a);
      return {a[31:5], 5'd0};
   endfunction

   function automatic logic [255:0] line_data(input logic [31:0] la);
      logic [255:0] d;
      d = 256'd0;
      for (int w = 0; w < 8; w++) d[32*w +: 32] = mem_word(la + 32'(4*w));
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Plays the memory: acks on the lat-th cycle the request is seen; leaves caller in FILL
   task automatic respond(input logic [31:0] la, input int lat);
      int en = 0;
      int guard = 0;
      while (en < lat && guard < 60) begin
         @(posedge clk_i); #1;
         guard++;
         if (mem_enable_o) begin
            en++;
            if (en == 1) chk("mem_addr", mem_addr_o, la);
            if (en == lat) begin
               mem_ack_i  = 1'b1;
               mem_data_i = line_data(la);
            end
         end
      end
      if (en < lat) chk("respond_timeout", 32'(en), 32'(lat));
      @(posedge clk_i); #1;
      mem_ack_i  = 1'b0;
      mem_data_i = 256'd0;
   endtask

   task automatic pop_check(input string name);
      logic [31:0] e;
      chk({name, "_stall"}, 32'(stall_o), 32'd0);
      if (exp_q.size() == 0) begin
         chk({name, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_inst"}, inst_o, e);
      end
   endtask

   task automatic fetch(input logic [31:0] a, input bit exp_miss, input int lat, input string name);
      int s0;
      @(posedge clk_i); #1;
      req_i  = 1'b1;
      addr_i = a;
      exp_q.push_back(mem_word(a));
      s0 = stall_cnt;
      @(negedge clk_i);
      chk({name, "_stall0"}, 32'(stall_o), 32'(exp_miss));
      if (exp_miss) begin
         respond(line_of(a), lat);
         @(posedge clk_i); #1;
         @(negedge clk_i);
      end
      pop_check(name);
      #1;
      if (exp_miss) chk({name, "_stall_cycles"}, 32'(stall_cnt - s0), 32'(lat + 2));
   endtask

   initial begin
      vecs[0]  = '{32'h0000_0040, 1'b1, 10};
      vecs[1]  = '{32'h0000_0044, 1'b0, 0};
      vecs[2]  = '{32'h0000_005C, 1'b0, 0};
      vecs[3]  = '{32'h0000_0240, 1'b1, 3};
      vecs[4]  = '{32'h0000_0248, 1'b0, 0};
      vecs[5]  = '{32'h0000_0040, 1'b1, 1};
      vecs[6]  = '{32'h0000_03E0, 1'b1, 2};
      vecs[7]  = '{32'h0000_03FC, 1'b0, 0};
      vecs[8]  = '{32'hFFFF_FFE0, 1'b1, 4};
      vecs[9]  = '{32'h0000_03E0, 1'b1, 2};
      vecs[10] = '{32'h0000_004C, 1'b0, 0};

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_enable", 32'(mem_enable_o), 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;

      for (int i = 0; i < 11; i++)
         fetch(vecs[i].addr, vecs[i].miss, vecs[i].lat, $sformatf("v%0d", i));

      // Invalidate while the refill is in FETCH
      @(posedge clk_i); #1;
      req_i = 1'b1; addr_i = 32'h0000_0080;
      exp_q.push_back(mem_word(32'h0000_0080));
      @(negedge clk_i);
      chk("invf_miss", 32'(stall_o), 32'd1);
      @(posedge clk_i); #1;
      inval_i = 1'b1;
      @(negedge clk_i);
      chk("invf_enable", 32'(mem_enable_o), 32'd1);
      @(posedge clk_i); #1;
      inval_i = 1'b0;
      respond(32'h0000_0080, 3);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      pop_check("invf_fill");
      fetch(32'h0000_0040, 1'b1, 2, "invf_old");
      fetch(32'h0000_0084, 1'b0, 0, "invf_keep");

      // Invalidate together with a miss in IDLE
      @(posedge clk_i); #1;
      addr_i = 32'h0000_0100; inval_i = 1'b1;
      exp_q.push_back(mem_word(32'h0000_0100));
      @(negedge clk_i);
      chk("invi_miss", 32'(stall_o), 32'd1);
      @(posedge clk_i); #1;
      inval_i = 1'b0;
      respond(32'h0000_0100, 2);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      pop_check("invi_fill");
      fetch(32'h0000_0080, 1'b1, 1, "invi_cleared");

      // Plain IDLE invalidate, then PC redirect during FETCH
      @(posedge clk_i); #1;
      req_i = 1'b0; inval_i = 1'b1;
      @(posedge clk_i); #1;
      inval_i = 1'b0;
      req_i = 1'b1; addr_i = 32'h0000_0040;
      @(negedge clk_i);
      chk("redir_miss0", 32'(stall_o), 32'd1);
      @(posedge clk_i); #1;
      addr_i = 32'h0000_0100;
      exp_q.push_back(mem_word(32'h0000_0100));
      respond(32'h0000_0040, 3);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("redir_miss1", 32'(stall_o), 32'd1);
      chk("redir_noen", 32'(mem_enable_o), 32'd0);
      respond(32'h0000_0100, 2);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      pop_check("redir_new");
      fetch(32'h0000_0040, 1'b0, 0, "redir_old_filled");

      // Reset in the middle of a refill, followed by a late ack
      @(posedge clk_i); #1;
      addr_i = 32'h0000_0060;
      @(negedge clk_i);
      chk("rstm_miss", 32'(stall_o), 32'd1);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("rstm_en_before", 32'(mem_enable_o), 32'd1);
      #1 rst_i = 1'b0;
      #1;
      chk("rstm_en", 32'(mem_enable_o), 32'd0);
      chk("rstm_stall", 32'(stall_o), 32'd0);
      chk("rstm_addr", mem_addr_o, 32'd0);
      @(posedge clk_i); #1;
      mem_ack_i = 1'b1; mem_data_i = ~line_data(32'h0000_0060);
      @(posedge clk_i); #1;
      rst_i = 1'b1; req_i = 1'b0;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0; mem_data_i = 256'd0;
      @(negedge clk_i);
      chk("rstm_idle_en", 32'(mem_enable_o), 32'd0);
      fetch(32'h0000_0060, 1'b1, 2, "rstm_next");
      fetch(32'h0000_0040, 1'b1, 2, "rstm_cleared");

      // Stray ack while idle
      @(posedge clk_i); #1;
      req_i = 1'b0; addr_i = 32'h0000_00C0;
      mem_ack_i = 1'b1; mem_data_i = line_data(32'h0000_00C0);
      @(negedge clk_i);
      chk("stray_stall", 32'(stall_o), 32'd0);
      chk("stray_en", 32'(mem_enable_o), 32'd0);
      chk("stray_inst0", inst_o, 32'd0);
      repeat (2) @(posedge clk_i);
      #1 mem_ack_i = 1'b0; mem_data_i = 256'd0;
      @(negedge clk_i);
      chk("stray_en_after", 32'(mem_enable_o), 32'd0);
      chk("stray_inst1", inst_o, 32'd0);
      fetch(32'h0000_00C0, 1'b1, 1, "stray_next");
      fetch(32'h0000_0060, 1'b0, 0, "stray_keep");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
